// File: rtl/qpsk_map_if.sv
// AXI-stream bundle shared by the QPSK mapper input (packed bytes) and output (IQ symbols).
// DW sets the payload width, UW the sideband tag width.
interface qpsk_map_if #(
  parameter int DW = 8,
  parameter int UW = 2
);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/qpsk_map.sv
// QPSK mapper: one packed byte in, four {Q, I} symbols out, fully back-pressurable at 1 symbol/clk.
// Optional symbol counter output m_symcnt_o is enabled by defining QPSK_MAP_SYMCNT_EN.
module qpsk_map #(
  parameter int IQ_DW = 16,
  parameter int AMP   = 11585
) (
  input  logic       clk_i,
  input  logic       reset_i,
  qpsk_map_if.slave  s_axis_in,
  qpsk_map_if.master m_axis_out
`ifdef QPSK_MAP_SYMCNT_EN
  ,
  output logic [15:0] m_symcnt_o
`endif
);

  localparam logic signed [IQ_DW-1:0] POS_AMP = IQ_DW'(AMP);
  localparam logic signed [IQ_DW-1:0] NEG_AMP = -POS_AMP;

  // Stage 1: byte buffer
  logic [7:0]         buf_data_q,  buf_data_d;
  logic [1:0]         buf_user_q,  buf_user_d;
  logic               buf_last_q,  buf_last_d;
  logic               buf_valid_q, buf_valid_d;
  logic [1:0]         idx_q,       idx_d;

  // Stage 2: output register
  logic [2*IQ_DW-1:0] out_data_q,  out_data_d;
  logic [1:0]         out_user_q,  out_user_d;
  logic               out_last_q,  out_last_d;
  logic               out_valid_q, out_valid_d;

  logic               load;
  logic               in_ready;
  logic               accept;
  logic               bit_i;
  logic               bit_q;
  logic [IQ_DW-1:0]   sym_i;
  logic [IQ_DW-1:0]   sym_q;

  always_comb begin
    load     = buf_valid_q && (!out_valid_q || m_axis_out.tready);
    // The buffer may refill in the very cycle its last symbol moves out, keeping output gap-free.
    in_ready = !reset_i && (!buf_valid_q || (idx_q == 2'd3 && load));
    accept   = s_axis_in.tvalid && in_ready;

    bit_i = buf_data_q[{idx_q, 1'b0}];
    bit_q = buf_data_q[{idx_q, 1'b1}];
    sym_i = bit_i ? NEG_AMP : POS_AMP;
    sym_q = bit_q ? NEG_AMP : POS_AMP;
  end

  // NOTE: every _d starts from its _q so no path through this block can leave a latch.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_user_d  = buf_user_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (load) begin
      out_data_d  = {sym_q, sym_i};
      out_user_d  = buf_user_q;
      out_last_d  = buf_last_q && (idx_q == 2'd3);
      out_valid_d = 1'b1;
      idx_d       = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        buf_valid_d = 1'b0;
      end
    end else if (m_axis_out.tready) begin
      // Payload is left as-is; only valid drops once the consumer has taken the symbol.
      out_valid_d = 1'b0;
    end

    // A byte accepted alongside the final load of the previous one overrides the clear above.
    if (accept) begin
      buf_data_d  = s_axis_in.tdata;
      buf_user_d  = s_axis_in.tuser;
      buf_last_d  = s_axis_in.tlast;
      buf_valid_d = 1'b1;
      idx_d       = 2'd0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_data_q  <= '0;
      buf_user_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_user_q  <= buf_user_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s_axis_in.tready  = in_ready;
  assign m_axis_out.tdata  = out_data_q;
  assign m_axis_out.tuser  = out_user_q;
  assign m_axis_out.tlast  = out_last_q;
  assign m_axis_out.tvalid = out_valid_q;

`ifdef QPSK_MAP_SYMCNT_EN
  logic [15:0] symcnt_q, symcnt_d;

  // Restarts after the tlast handshake so the count is 0 at every codeword start.
  always_comb begin
    symcnt_d = symcnt_q;
    if (out_valid_q && m_axis_out.tready) begin
      symcnt_d = out_last_q ? 16'd0 : symcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      symcnt_q <= '0;
    end else begin
      symcnt_q <= symcnt_d;
    end
  end

  assign m_symcnt_o = symcnt_q;
`endif

endmodule

// File: tb/tb_qpsk_map.sv
// Directed bench for qpsk_map: reset state, symbol mapping, back-to-back bytes, stall, mid-byte
// reset and a randomized handshake scoreboard run.
module tb_qpsk_map;

  localparam logic [15:0] P = 16'h2D41;
  localparam logic [15:0] N = 16'hD2BF;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  qpsk_map_if #(.DW(8),  .UW(2)) in_if ();
  qpsk_map_if #(.DW(32), .UW(2)) out_if ();

`ifdef QPSK_MAP_SYMCNT_EN
  logic [15:0] symcnt;
`endif

  qpsk_map #(.IQ_DW(16), .AMP(11585)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .s_axis_in  (in_if),
    .m_axis_out (out_if)
`ifdef QPSK_MAP_SYMCNT_EN
    ,
    .m_symcnt_o (symcnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sym(input logic [7:0] b, input int k);
    logic [15:0] i_c;
    logic [15:0] q_c;
    i_c = b[2*k]   ? N : P;
    q_c = b[2*k+1] ? N : P;
    return {q_c, i_c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] t1_exp [4];
  logic [34:0] expq [$];
  logic [34:0] e;
  int          acc_cyc [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nsym, first, last_c, cnt, sent, tl_in, tl_out, extras;
    logic acc, in_hs, out_hs;

    t1_exp = '{32'hD2BFD2BF, 32'hD2BF2D41, 32'h2D41D2BF, 32'h2D412D41};
    reset_i       = 1'b1;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tuser   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;

    #12;
    check("rst_in_ready_low", in_if.tready, 1'b0);
    reset_i = 1'b0;
    #1;
    check("rst_tvalid", out_if.tvalid, 1'b0);
    check("rst_tdata",  out_if.tdata,  32'h0);
    check("rst_tlast",  out_if.tlast,  1'b0);
    check("rst_tuser",  out_if.tuser,  2'd0);
    check("rst_in_ready_high", in_if.tready, 1'b1);
    tick();

    // Byte 0x1B: mapping, tuser repeat, tlast on 4th, two-edge latency
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'h1B;
    in_if.tuser  = 2'd1;
    in_if.tlast  = 1'b1;
    settle();
    check("t1_in_ready", in_if.tready, 1'b1);
    tick();
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 2'd0;
    check("t1_not_valid_yet", out_if.tvalid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_valid", out_if.tvalid, 1'b1);
      check("t1_data",  out_if.tdata,  t1_exp[k]);
      check("t1_user",  out_if.tuser,  2'd1);
      check("t1_last",  out_if.tlast,  (k == 3));
    end
    tick();
    check("t1_valid_drop", out_if.tvalid, 1'b0);

    // Eight back-to-back bytes 0x00..0x07
    nb = 0; nsym = 0; first = -1; last_c = -1;
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'h00;
    in_if.tuser  = 2'd2;
    for (int c = 0; c < 45; c++) begin
      settle();
      acc = in_if.tvalid && in_if.tready;
      if (acc) acc_cyc.push_back(c);
      if (out_if.tvalid) begin
        check("b2b_sym", out_if.tdata, sym(8'(nsym / 4), nsym % 4));
        if (first < 0) first = c;
        last_c = c;
        nsym++;
      end
      tick();
      if (acc) begin
        nb++;
        if (nb == 8) in_if.tvalid = 1'b0;
        else in_if.tdata = 8'(nb);
      end
    end
    check("b2b_count", nsym, 32);
    check("b2b_contiguous", last_c - first + 1, 32);
    check("b2b_accepts", acc_cyc.size(), 8);
    for (int j = 1; j < acc_cyc.size(); j++) begin
      check("b2b_ready_period", acc_cyc[j] - acc_cyc[j-1], 4);
    end

    // Byte 0xFF with a 5-cycle output stall
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'hFF;
    in_if.tuser  = 2'd3;
    in_if.tlast  = 1'b1;
    settle();
    tick();
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    tick();
    check("stall_first_valid", out_if.tvalid, 1'b1);
    out_if.tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("stall_data",     out_if.tdata,  32'hD2BFD2BF);
      check("stall_valid",    out_if.tvalid, 1'b1);
      check("stall_in_ready", in_if.tready,  1'b0);
      tick();
    end
    out_if.tready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (out_if.tvalid) begin
        cnt++;
        check("stall_rel_data", out_if.tdata, 32'hD2BFD2BF);
        check("stall_rel_user", out_if.tuser, 2'd3);
        check("stall_rel_last", out_if.tlast, (cnt == 4));
      end
      tick();
    end
    check("stall_rel_count", cnt, 4);

    // Reset after the 2nd symbol of 0xAA, then 0x55
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'hAA;
    in_if.tuser  = 2'd0;
    settle();
    tick();
    in_if.tvalid = 1'b0;
    tick();
    check("rst_mid_sym0", out_if.tdata, 32'hD2BF2D41);
    tick();
    check("rst_mid_sym1", out_if.tdata, 32'hD2BF2D41);
    settle();
    reset_i = 1'b1;
    #1;
    check("rst_mid_tvalid",   out_if.tvalid, 1'b0);
    check("rst_mid_tdata",    out_if.tdata,  32'h0);
    check("rst_mid_tlast",    out_if.tlast,  1'b0);
    check("rst_mid_in_ready", in_if.tready,  1'b0);
    tick();
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_mid_quiet", out_if.tvalid, 1'b0);
    end
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'h55;
    settle();
    tick();
    in_if.tvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (out_if.tvalid) begin
        cnt++;
        check("rst_55_data", out_if.tdata, 32'h2D41D2BF);
      end
      tick();
    end
    check("rst_55_count", cnt, 4);

    // Random handshakes over 1000 bytes against a scoreboard
    sent = 0; tl_in = 0; tl_out = 0; extras = 0;
    in_if.tvalid = 1'b0;
    for (int c = 0; c < 20000 && (sent < 1000 || expq.size() != 0); c++) begin
      if (!in_if.tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_if.tvalid = 1'b1;
        in_if.tdata  = 8'($urandom);
        in_if.tuser  = 2'($urandom);
        in_if.tlast  = ($urandom_range(0, 4) == 0);
      end
      out_if.tready = ($urandom_range(0, 3) != 0);
      settle();
      in_hs  = in_if.tvalid && in_if.tready;
      out_hs = out_if.tvalid && out_if.tready;
      if (out_hs) begin
        if (out_if.tlast) tl_out++;
        if (expq.size() == 0) extras++;
        else begin
          e = expq.pop_front();
          check("rnd_sym", {out_if.tlast, out_if.tuser, out_if.tdata}, e);
        end
      end
      if (in_hs) begin
        for (int k = 0; k < 4; k++) begin
          expq.push_back({in_if.tlast && (k == 3), in_if.tuser, sym(in_if.tdata, k)});
        end
        sent++;
        if (in_if.tlast) tl_in++;
      end
      tick();
      if (in_hs) in_if.tvalid = 1'b0;
    end
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b1;
    check("rnd_sent",   sent, 1000);
    check("rnd_left",   expq.size(), 0);
    check("rnd_extras", extras, 0);
    check("rnd_tlast",  tl_out, tl_in);

`ifdef QPSK_MAP_SYMCNT_EN
    // Two 3-byte codewords through the symbol counter
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    nb = 0;
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'h00;
    in_if.tlast  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      settle();
      acc    = in_if.tvalid && in_if.tready;
      out_hs = out_if.tvalid && out_if.tready && out_if.tlast;
      if (out_hs) check("cnt_before_tlast", symcnt, 16'd11);
      tick();
      if (out_hs) check("cnt_after_tlast", symcnt, 16'd0);
      if (acc) begin
        nb++;
        if (nb == 6) in_if.tvalid = 1'b0;
        in_if.tdata = 8'(nb * 37);
        in_if.tlast = (nb == 2 || nb == 5);
      end
    end
    in_if.tlast = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
